// File: rtl/rotator_pkg.sv
// Shared types and helpers for the column-transposing BRAM writer.
// Imported by rot_sc_fifo and bit_pixel_rotator_nbuf.
package rotator_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // sideband offsets above the pixel field of in_data
  localparam int EOF_OFS = 0;
  localparam int SOF_OFS = 1;
  localparam int SEC_OFS = 2;
  localparam int SIDE_W  = 4;

  function automatic int cols_words(
    input logic [1:0] section,
    input int         center_idx,
    input int         center_cols,
    input int         side_cols,
    input int         num_pix
  );
    if (int'(section) == center_idx)
      return center_cols / num_pix;
    return side_cols / num_pix;
  endfunction

endpackage

// File: rtl/rot_sc_fifo.sv
// Single-clock show-ahead FIFO with synchronous clear.
// q always presents the oldest word while !empty.
module rot_sc_fifo
  import rotator_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     sclr,
  input  logic                     wr_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_req,
  output logic [WIDTH-1:0]         q,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   usedw
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_req && !full;
  assign do_rd = rd_req && !empty;
  assign empty = (usedw == '0);
  assign full  = (usedw == UW'(DEPTH));
  assign q     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   usedw <= usedw + 1'b1;
        2'b01:   usedw <= usedw - 1'b1;
        default: usedw <= usedw;
      endcase
    end
  end

endmodule

// File: rtl/bit_pixel_rotator_nbuf.sv
// Column-major in, row-major out BRAM writer over a NUM_BUFS frame ring.
// Define ROTATOR_SOF_RESYNC_EN to realign on sof and expose resync_count.
module bit_pixel_rotator_nbuf
  import rotator_pkg::*;
#(
  parameter int NUM_PIX      = 16,
  parameter int SIDE_COLS    = 240,
  parameter int CENTER_COLS  = 304,
  parameter int ROWS         = 480,
  parameter int NUM_SECTIONS = 3,
  parameter int CENTER_IDX   = 1,
  parameter int NUM_BUFS     = 2,
  parameter int FIFO_DEPTH   = 512,
  parameter int AFULL_THRESH = 32,
  parameter int ADDR_W       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PIX+7:0]          in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NUM_PIX-1:0]          wr_data,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [1:0]                  wr_section,
  output logic [$clog2(NUM_BUFS)-1:0] wr_buf,
  input  logic [NUM_BUFS-1:0]         bm_busy_mask,
  output logic                        frame_done,
  output logic [$clog2(NUM_BUFS)-1:0] frame_buf,
  output logic [3:0]                  image_number,
  output logic                        stalled,
  output logic                        overflow
`ifdef ROTATOR_SOF_RESYNC_EN
  ,
  output logic [7:0]                  resync_count
`endif
);

  localparam int BW     = $clog2(NUM_BUFS);
  localparam int DW     = NUM_PIX + SIDE_W;
  localparam int UW     = $clog2(FIFO_DEPTH) + 1;
  localparam int CW_S   = SIDE_COLS / NUM_PIX;
  localparam int CW_C   = CENTER_COLS / NUM_PIX;
  localparam int CW_MAX = (CW_C > CW_S) ? CW_C : CW_S;
  localparam int CLW    = $clog2(CW_MAX + 1);
  localparam int RW     = $clog2(ROWS + 1);

  localparam logic [ADDR_W-1:0] SZ_S = ADDR_W'(CW_S * ROWS);
  localparam logic [ADDR_W-1:0] SZ_C = ADDR_W'(CW_C * ROWS);

  state_t            state;
  logic [BW-1:0]     buf_idx;
  logic [BW-1:0]     nxt;
  logic [RW-1:0]     row;
  logic [RW-1:0]     eff_row;
  logic [CLW-1:0]    col;
  logic [CLW-1:0]    eff_col;
  logic [CLW-1:0]    cols_w;
  logic [ADDR_W-1:0] offs;
  logic [ADDR_W-1:0] eff_offs;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] base_s;
  logic [ADDR_W-1:0] base_c;
  logic [DW-1:0]     head;
  logic [1:0]        head_sec;
  logic [UW-1:0]     usedw;
  logic [UW-1:0]     used_nxt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              sec_ok;
  logic              is_ctr;
  logic              row_last;
  logic              col_last;
  logic              sec_end;
  logic              frame_end;
  logic              busy_nxt;
  logic              adv;
  logic              resync;
  logic              unused_bits;

  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign used_nxt = usedw + UW'(push) - UW'(pop);

  rot_sc_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .sclr    (reset),
    .wr_req  (push),
    .wr_data (in_data[DW-1:0]),
    .rd_req  (pop),
    .q       (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .usedw   (usedw)
  );

  assign head_sec = head[NUM_PIX+SEC_OFS +: 2];
  assign sec_ok   = int'(head_sec) < NUM_SECTIONS;
  assign is_ctr   = (head_sec == 2'(CENTER_IDX));
  assign cols_w   = CLW'(cols_words(head_sec, CENTER_IDX,
                                    CENTER_COLS, SIDE_COLS, NUM_PIX));
  assign stride   = ADDR_W'(cols_w);

  // out-of-range sections are drained without a write
  assign wr_en = pop && sec_ok;

  assign nxt      = (buf_idx == BW'(NUM_BUFS - 1)) ? '0 : buf_idx + 1'b1;
  assign busy_nxt = bm_busy_mask[nxt];

`ifdef ROTATOR_SOF_RESYNC_EN
  logic sec_act;
  assign resync = head[NUM_PIX+SOF_OFS] && (head_sec == 2'd0) &&
                  (row != '0 || col != '0 || sec_act);
`else
  assign resync = 1'b0;
`endif

  assign eff_row  = resync ? '0 : row;
  assign eff_col  = resync ? '0 : col;
  assign eff_offs = resync ? '0 : offs;

  assign row_last  = (eff_row == RW'(ROWS - 1));
  assign col_last  = (eff_col == cols_w - 1'b1);
  assign sec_end   = row_last && col_last;
  assign frame_end = wr_en && sec_end &&
                     (head_sec == 2'(NUM_SECTIONS - 1));
  assign adv       = !busy_nxt && (frame_end || state == ST_STALL);

  assign wr_addr    = wr_en ? (is_ctr ? base_c : base_s) + eff_offs : '0;
  assign wr_data    = wr_en ? head[NUM_PIX-1:0] : '0;
  assign wr_section = wr_en ? head_sec : '0;
  assign wr_buf     = buf_idx;

  assign unused_bits = ^{in_data[NUM_PIX+7:NUM_PIX+4],
                         head[NUM_PIX+EOF_OFS],
                         head[NUM_PIX+SOF_OFS], fifo_full};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      buf_idx      <= '0;
      row          <= '0;
      col          <= '0;
      offs         <= '0;
      base_s       <= '0;
      base_c       <= '0;
      in_ready     <= 1'b0;
      frame_done   <= 1'b0;
      frame_buf    <= '0;
      image_number <= '0;
      stalled      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      in_ready   <= (used_nxt < UW'(AFULL_THRESH));
      frame_done <= frame_end;
      if (in_valid && !in_ready)
        overflow <= 1'b1;
      if (frame_end) begin
        frame_buf    <= buf_idx;
        image_number <= image_number + 4'd1;
      end
      // row runs fastest; a column step rebases onto the next column
      if (wr_en) begin
        if (sec_end) begin
          row  <= '0;
          col  <= '0;
          offs <= '0;
        end else if (row_last) begin
          row  <= '0;
          col  <= eff_col + 1'b1;
          offs <= ADDR_W'(eff_col) + 1'b1;
        end else begin
          row  <= eff_row + 1'b1;
          col  <= eff_col;
          offs <= eff_offs + stride;
        end
      end
      if (adv) begin
        state   <= ST_IDLE;
        stalled <= 1'b0;
        buf_idx <= nxt;
        base_s  <= (nxt == '0) ? '0 : base_s + SZ_S;
        base_c  <= (nxt == '0) ? '0 : base_c + SZ_C;
      end else if (frame_end) begin
        state   <= ST_STALL;
        stalled <= 1'b1;
      end
    end
  end

`ifdef ROTATOR_SOF_RESYNC_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_act      <= 1'b0;
      resync_count <= '0;
    end else if (wr_en) begin
      if (frame_end)
        sec_act <= 1'b0;
      else if (sec_end)
        sec_act <= 1'b1;
      else if (resync)
        sec_act <= 1'b0;
      if (resync && resync_count != 8'hFF)
        resync_count <= resync_count + 8'd1;
    end
  end
`endif

endmodule
